perif_regbank_axi: RTL and testbench



---
 rtl/perif_regbank_pkg.sv | 33 +++
 rtl/perif_regbank_wr_ch.sv | 161 ++++++++++++++++
 rtl/perif_regbank_axi.sv | 165 ++++++++++++++++
 tb/tb_perif_regbank_axi.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/perif_regbank_pkg.sv
// perif_regbank_pkg: shared definitions for the AXI4-Lite register bank.
//   - AXI response codes (OKAY / SLVERR)
//   - write-channel and read-channel state encodings
//   - helpers that derive the byte-offset width and register-index width
//     from the AXI address/data widths
package perif_regbank_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE,
    W_COMMIT,
    W_RESP
  } wr_state_e;

  typedef enum logic {
    R_IDLE,
    R_RESP
  } rd_state_e;

  // Number of byte-offset bits below the register index.
  function automatic int unsigned byte_lsb(input int unsigned data_w);
    return $clog2(data_w / 8);
  endfunction

  // Width of the register index carved out of the byte address.
  function automatic int unsigned idx_width(input int unsigned addr_w,
                                            input int unsigned data_w);
    return addr_w - byte_lsb(data_w);
  endfunction

endpackage

// File: rtl/perif_regbank_wr_ch.sv
// perif_regbank_wr_ch: AXI4-Lite write channel of the register bank.
// Accepts AW and W independently (either order or together), commits the
// byte-strobed data into the addressed control register for one cycle in
// W_COMMIT, and returns OKAY for control registers or SLVERR for anything
// else (status, ID or unmapped) without changing state.
//
// Ports:
//   clk_i, srst_i              clock, synchronous active-high reset
//   awaddr_i/awvalid_i/awready_o   write address channel
//   wdata_i/wstrb_i/wvalid_i/wready_o  write data channel
//   bresp_o/bvalid_o/bready_i  write response channel
//   ctrl_o                     packed control registers, reg i at [i*DW +: DW]
//   wr_pulse_o                 one-cycle strobe per control register on an
//                              OKAY write (only with PERIF_REGBANK_WR_PULSE_EN)
//
// Optional feature macro: PERIF_REGBANK_WR_PULSE_EN
module perif_regbank_wr_ch
  import perif_regbank_pkg::*;
#(
  parameter int DW     = 32,
  parameter int AW     = 6,
  parameter int NUM_RW = 4,
  parameter logic [DW-1:0] RW_RESET_VALUE = '0
) (
  input  logic                 clk_i,
  input  logic                 srst_i,
  input  logic [AW-1:0]        awaddr_i,
  input  logic                 awvalid_i,
  output logic                 awready_o,
  input  logic [DW-1:0]        wdata_i,
  input  logic [DW/8-1:0]      wstrb_i,
  input  logic                 wvalid_i,
  output logic                 wready_o,
  output logic [1:0]           bresp_o,
  output logic                 bvalid_o,
  input  logic                 bready_i,
  output logic [NUM_RW*DW-1:0] ctrl_o
`ifdef PERIF_REGBANK_WR_PULSE_EN
  ,
  output logic [NUM_RW-1:0]    wr_pulse_o
`endif
);

  localparam int LSB  = byte_lsb(DW);
  localparam int IDXW = idx_width(AW, DW);
  localparam logic [IDXW-1:0] RO_BASE = IDXW'(NUM_RW);

  wr_state_e        state_q;
  logic             awready_q, wready_q;
  logic             aw_have_q, w_have_q;
  logic [IDXW-1:0]  awidx_q;
  logic [DW-1:0]    wdata_q;
  logic [DW/8-1:0]  wstrb_q;
  logic             bvalid_q;
  logic [1:0]       bresp_q;

  logic             aw_hs, w_hs, start_commit;
  logic [IDXW-1:0]  idx_in, idx_d;
  logic             unused_lo;

  assign aw_hs  = awvalid_i && awready_q;
  assign w_hs   = wvalid_i && wready_q;
  assign idx_in = awaddr_i[AW-1:LSB];
  // Index of the write that is about to commit: the address may arrive in
  // the very cycle the second half of the pair is accepted.
  assign idx_d  = aw_hs ? idx_in : awidx_q;
  assign start_commit = (state_q == W_IDLE) && (aw_have_q || aw_hs) && (w_have_q || w_hs);
  assign unused_lo = ^awaddr_i[LSB-1:0];

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_q   <= W_IDLE;
      awready_q <= 1'b1;
      wready_q  <= 1'b1;
      aw_have_q <= 1'b0;
      w_have_q  <= 1'b0;
      awidx_q   <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
    end else begin
      case (state_q)
        W_IDLE: begin
          if (aw_hs) begin
            awidx_q   <= idx_in;
            aw_have_q <= 1'b1;
            awready_q <= 1'b0;
          end
          if (w_hs) begin
            wdata_q  <= wdata_i;
            wstrb_q  <= wstrb_i;
            w_have_q <= 1'b1;
            wready_q <= 1'b0;
          end
          // bvalid is raised on entry so it is visible during the commit cycle.
          if (start_commit) begin
            bvalid_q <= 1'b1;
            bresp_q  <= (idx_d < RO_BASE) ? RESP_OKAY : RESP_SLVERR;
            state_q  <= W_COMMIT;
          end
        end
        W_COMMIT, W_RESP: begin
          if (bready_i) begin
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
            aw_have_q <= 1'b0;
            w_have_q  <= 1'b0;
            state_q   <= W_IDLE;
          end else begin
            state_q   <= W_RESP;
          end
        end
        default: state_q <= W_IDLE;
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_RW; gi++) begin : g_rw
      logic [DW-1:0] reg_q;
      always_ff @(posedge clk_i) begin
        if (srst_i) begin
          reg_q <= RW_RESET_VALUE;
        end else if (state_q == W_COMMIT && awidx_q == IDXW'(gi)) begin
          for (int b = 0; b < DW / 8; b++) begin
            if (wstrb_q[b]) reg_q[b*8 +: 8] <= wdata_q[b*8 +: 8];
          end
        end
      end
      assign ctrl_o[gi*DW +: DW] = reg_q;
    end
  endgenerate

`ifdef PERIF_REGBANK_WR_PULSE_EN
  // Registered on entry to W_COMMIT so the pulse covers exactly that cycle;
  // fires even for an all-zero strobe as long as the target is writable.
  logic [NUM_RW-1:0] wr_pulse_q;
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      wr_pulse_q <= '0;
    end else begin
      wr_pulse_q <= '0;
      if (start_commit) begin
        for (int i = 0; i < NUM_RW; i++) begin
          if (idx_d == IDXW'(i)) wr_pulse_q[i] <= 1'b1;
        end
      end
    end
  end
  assign wr_pulse_o = wr_pulse_q;
`endif

  assign awready_o = awready_q;
  assign wready_o  = wready_q;
  assign bvalid_o  = bvalid_q;
  assign bresp_o   = bresp_q;

endmodule

// File: rtl/perif_regbank_axi.sv
// perif_regbank_axi: AXI4-Lite slave register bank.
// Register map (index = byte address >> log2(DATA_WIDTH/8)):
//   0 .. NUM_RW-1               read/write control registers (ctrl_out)
//   NUM_RW .. NUM_RW+NUM_RO-1   read-only status words (status_in)
//   NUM_RW+NUM_RO               ID register returning CONSTANT_VALUE
//   above                       unmapped: reads 0 / SLVERR, writes SLVERR
//
// Ports:
//   s00_axi_aclk, s00_axi_areset  clock, synchronous active-high reset
//   s00_axi_aw*/w*/b*             AXI4-Lite write channels (awprot ignored)
//   s00_axi_ar*/r*                AXI4-Lite read channels (arprot ignored)
//   ctrl_out                      control registers, reg i at [i*DW +: DW]
//   status_in                     status words, same packing
//   wr_pulse                      one-cycle write strobe per control register
//                                 (only with PERIF_REGBANK_WR_PULSE_EN)
//
// Optional feature macro: PERIF_REGBANK_WR_PULSE_EN
module perif_regbank_axi
  import perif_regbank_pkg::*;
#(
  parameter int C_S00_AXI_DATA_WIDTH = 32,
  parameter int C_S00_AXI_ADDR_WIDTH = 6,
  parameter int NUM_RW = 4,
  parameter int NUM_RO = 4,
  parameter logic [C_S00_AXI_DATA_WIDTH-1:0] CONSTANT_VALUE = 'h123456,
  parameter logic [C_S00_AXI_DATA_WIDTH-1:0] RW_RESET_VALUE = '0
) (
  input  logic                                   s00_axi_aclk,
  input  logic                                   s00_axi_areset,
  input  logic [C_S00_AXI_ADDR_WIDTH-1:0]        s00_axi_awaddr,
  input  logic [2:0]                             s00_axi_awprot,
  input  logic                                   s00_axi_awvalid,
  output logic                                   s00_axi_awready,
  input  logic [C_S00_AXI_DATA_WIDTH-1:0]        s00_axi_wdata,
  input  logic [C_S00_AXI_DATA_WIDTH/8-1:0]      s00_axi_wstrb,
  input  logic                                   s00_axi_wvalid,
  output logic                                   s00_axi_wready,
  output logic [1:0]                             s00_axi_bresp,
  output logic                                   s00_axi_bvalid,
  input  logic                                   s00_axi_bready,
  input  logic [C_S00_AXI_ADDR_WIDTH-1:0]        s00_axi_araddr,
  input  logic [2:0]                             s00_axi_arprot,
  input  logic                                   s00_axi_arvalid,
  output logic                                   s00_axi_arready,
  output logic [C_S00_AXI_DATA_WIDTH-1:0]        s00_axi_rdata,
  output logic [1:0]                             s00_axi_rresp,
  output logic                                   s00_axi_rvalid,
  input  logic                                   s00_axi_rready,
  output logic [NUM_RW*C_S00_AXI_DATA_WIDTH-1:0] ctrl_out,
  input  logic [NUM_RO*C_S00_AXI_DATA_WIDTH-1:0] status_in
`ifdef PERIF_REGBANK_WR_PULSE_EN
  ,
  output logic [NUM_RW-1:0]                      wr_pulse
`endif
);

  localparam int DW   = C_S00_AXI_DATA_WIDTH;
  localparam int AW   = C_S00_AXI_ADDR_WIDTH;
  localparam int LSB  = byte_lsb(DW);
  localparam int IDXW = idx_width(AW, DW);
  localparam logic [IDXW-1:0] ID_IDX = IDXW'(NUM_RW + NUM_RO);

  logic [NUM_RW*DW-1:0] ctrl_flat;

  perif_regbank_wr_ch #(
    .DW             (DW),
    .AW             (AW),
    .NUM_RW         (NUM_RW),
    .RW_RESET_VALUE (RW_RESET_VALUE)
  ) u_wr_ch (
    .clk_i      (s00_axi_aclk),
    .srst_i     (s00_axi_areset),
    .awaddr_i   (s00_axi_awaddr),
    .awvalid_i  (s00_axi_awvalid),
    .awready_o  (s00_axi_awready),
    .wdata_i    (s00_axi_wdata),
    .wstrb_i    (s00_axi_wstrb),
    .wvalid_i   (s00_axi_wvalid),
    .wready_o   (s00_axi_wready),
    .bresp_o    (s00_axi_bresp),
    .bvalid_o   (s00_axi_bvalid),
    .bready_i   (s00_axi_bready),
    .ctrl_o     (ctrl_flat)
`ifdef PERIF_REGBANK_WR_PULSE_EN
    ,
    .wr_pulse_o (wr_pulse)
`endif
  );

  assign ctrl_out = ctrl_flat;

  // ---------------- read path ----------------
  rd_state_e        rd_state_q;
  logic             arready_q, rvalid_q;
  logic [DW-1:0]    rdata_q;
  logic [1:0]       rresp_q;

  logic [IDXW-1:0]  ar_idx;
  logic [DW-1:0]    rd_word;
  logic [1:0]       rd_resp;
  logic             unused_in;

  assign ar_idx    = s00_axi_araddr[AW-1:LSB];
  assign unused_in = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_araddr[LSB-1:0]};

  // Word selected by the presented read address. Sampled only on the AR
  // handshake, so control registers show their pre-commit value if a write
  // commits in that same cycle.
  always_comb begin
    rd_word = '0;
    rd_resp = RESP_SLVERR;
    for (int i = 0; i < NUM_RW; i++) begin
      if (ar_idx == IDXW'(i)) begin
        rd_word = ctrl_flat[i*DW +: DW];
        rd_resp = RESP_OKAY;
      end
    end
    for (int i = 0; i < NUM_RO; i++) begin
      if (ar_idx == IDXW'(NUM_RW + i)) begin
        rd_word = status_in[i*DW +: DW];
        rd_resp = RESP_OKAY;
      end
    end
    if (ar_idx == ID_IDX) begin
      rd_word = CONSTANT_VALUE;
      rd_resp = RESP_OKAY;
    end
  end

  always_ff @(posedge s00_axi_aclk) begin
    if (s00_axi_areset) begin
      rd_state_q <= R_IDLE;
      arready_q  <= 1'b1;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
    end else begin
      case (rd_state_q)
        R_IDLE: begin
          if (s00_axi_arvalid && arready_q) begin
            rdata_q    <= rd_word;
            rresp_q    <= rd_resp;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b1;
            rd_state_q <= R_RESP;
          end
        end
        R_RESP: begin
          if (s00_axi_rready) begin
            rvalid_q   <= 1'b0;
            arready_q  <= 1'b1;
            rd_state_q <= R_IDLE;
          end
        end
        default: rd_state_q <= R_IDLE;
      endcase
    end
  end

  assign s00_axi_arready = arready_q;
  assign s00_axi_rvalid  = rvalid_q;
  assign s00_axi_rdata   = rdata_q;
  assign s00_axi_rresp   = rresp_q;

endmodule

// File: tb/tb_perif_regbank_axi.sv
module tb_perif_regbank_axi;

  localparam int DW = 32;
  localparam int AW = 6;

  logic             clk = 1'b0;
  logic             areset = 1'b1;
  logic [AW-1:0]    awaddr = '0;
  logic [2:0]       awprot = '0;
  logic             awvalid = 1'b0;
  logic             awready;
  logic [DW-1:0]    wdata = '0;
  logic [3:0]       wstrb = '0;
  logic             wvalid = 1'b0;
  logic             wready;
  logic [1:0]       bresp;
  logic             bvalid;
  logic             bready = 1'b0;
  logic [AW-1:0]    araddr = '0;
  logic [2:0]       arprot = '0;
  logic             arvalid = 1'b0;
  logic             arready;
  logic [DW-1:0]    rdata;
  logic [1:0]       rresp;
  logic             rvalid;
  logic             rready = 1'b0;
  logic [127:0]     ctrl_out;
  logic [127:0]     status_in;
`ifdef PERIF_REGBANK_WR_PULSE_EN
  logic [3:0]       wr_pulse;
`endif

  always #5 clk = ~clk;

  perif_regbank_axi dut (
    .s00_axi_aclk    (clk),
    .s00_axi_areset  (areset),
    .s00_axi_awaddr  (awaddr),
    .s00_axi_awprot  (awprot),
    .s00_axi_awvalid (awvalid),
    .s00_axi_awready (awready),
    .s00_axi_wdata   (wdata),
    .s00_axi_wstrb   (wstrb),
    .s00_axi_wvalid  (wvalid),
    .s00_axi_wready  (wready),
    .s00_axi_bresp   (bresp),
    .s00_axi_bvalid  (bvalid),
    .s00_axi_bready  (bready),
    .s00_axi_araddr  (araddr),
    .s00_axi_arprot  (arprot),
    .s00_axi_arvalid (arvalid),
    .s00_axi_arready (arready),
    .s00_axi_rdata   (rdata),
    .s00_axi_rresp   (rresp),
    .s00_axi_rvalid  (rvalid),
    .s00_axi_rready  (rready),
    .ctrl_out        (ctrl_out),
    .status_in       (status_in)
`ifdef PERIF_REGBANK_WR_PULSE_EN
    ,
    .wr_pulse        (wr_pulse)
`endif
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Write transaction; order 0 = AW and W together, 1 = AW first, 2 = W first.
  task automatic axi_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input logic [3:0] s, input int order, output logic [1:0] resp);
    bit aw_done = 0, w_done = 0;
    bit aw_fire, w_fire;
    int n = 0;
    awaddr = a; wdata = d; wstrb = s;
    awvalid = (order != 2);
    wvalid  = (order != 1);
    for (int c = 0; c < 16 && !(aw_done && w_done); c++) begin
      aw_fire = awvalid && awready;
      w_fire  = wvalid && wready;
      @(posedge clk); #1;
      if (aw_fire) begin awvalid = 0; aw_done = 1; end
      if (w_fire)  begin wvalid = 0;  w_done = 1;  end
      if (aw_done && !w_done) begin
        check("awready_drop", awready, 1'b0);
        wvalid = 1;
      end
      if (w_done && !aw_done) begin
        check("wready_drop", wready, 1'b0);
        awvalid = 1;
      end
    end
    awvalid = 0; wvalid = 0;
    check("wr_handshake_done", aw_done && w_done, 1'b1);
    while (!bvalid && n < 8) begin @(posedge clk); #1; n++; end
    check("bvalid_latency", n, 0);
    resp = bresp;
    bready = 1;
    @(posedge clk); #1;
    bready = 0;
    check("bvalid_clear", {bvalid, awready, wready}, 3'b011);
  endtask

  task automatic axi_read(input logic [AW-1:0] a, output logic [DW-1:0] d, output logic [1:0] resp);
    bit done = 0;
    bit fire;
    araddr = a;
    arvalid = 1;
    for (int c = 0; c < 16 && !done; c++) begin
      fire = arvalid && arready;
      @(posedge clk); #1;
      if (fire) begin arvalid = 0; done = 1; end
    end
    arvalid = 0;
    check("ar_handshake_done", done, 1'b1);
    check("rvalid_latency", rvalid, 1'b1);
    d = rdata;
    resp = rresp;
    rready = 1;
    @(posedge clk); #1;
    rready = 0;
    check("rvalid_clear", {rvalid, arready}, 2'b01);
  endtask

  typedef struct {
    bit           is_wr;
    logic [5:0]   addr;
    logic [31:0]  data;
    logic [3:0]   strb;
    int           order;
    logic [1:0]   exp_resp;
    logic [31:0]  exp_rdata;
    logic [127:0] exp_ctrl;
  } vec_t;

  localparam int NVEC = 18;
  vec_t vecs[NVEC];

  localparam logic [31:0] S0 = 32'h5A5A0000, S1 = 32'h11112222,
                          S2 = 32'hCAFE0001, S3 = 32'h0BADF00D;
  localparam logic [127:0] C0 = '0;
  localparam logic [127:0] C1 = {32'h0, 32'h0, 32'h00AD00EF, 32'h0};
  localparam logic [127:0] C2 = {32'h0, 32'h0, 32'h00AD00EF, 32'h00000001};
  localparam logic [127:0] C3 = {32'hA5000000, 32'h0, 32'h00AD00EF, 32'h00000001};
  localparam logic [127:0] C4 = {32'hA5000000, 32'h00005678, 32'h00AD00EF, 32'h00000001};

  int pulse3_cnt = 0, pulse_other_cnt = 0;
  bit mon_en = 0;
`ifdef PERIF_REGBANK_WR_PULSE_EN
  always @(negedge clk) begin
    if (mon_en) begin
      pulse3_cnt      += int'(wr_pulse[3]);
      pulse_other_cnt += int'(wr_pulse[0]) + int'(wr_pulse[1]) + int'(wr_pulse[2]);
    end
  end
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  resp;
    logic [31:0] rd;

    //            wr  addr   data          strb   ord resp    rdata          ctrl
    vecs[0]  = '{0, 6'h20, 32'h0,        4'h0, 0, 2'b00, 32'h00123456, C0};
    vecs[1]  = '{1, 6'h04, 32'hDEADBEEF, 4'h5, 2, 2'b00, 32'h0,        C1};
    vecs[2]  = '{0, 6'h04, 32'h0,        4'h0, 0, 2'b00, 32'h00AD00EF, C1};
    vecs[3]  = '{0, 6'h18, 32'h0,        4'h0, 0, 2'b00, S2,           C1};
    vecs[4]  = '{1, 6'h10, 32'h11111111, 4'hF, 1, 2'b10, 32'h0,        C1};
    vecs[5]  = '{1, 6'h30, 32'h22222222, 4'hF, 0, 2'b10, 32'h0,        C1};
    vecs[6]  = '{0, 6'h30, 32'h0,        4'h0, 0, 2'b10, 32'h0,        C1};
    vecs[7]  = '{1, 6'h00, 32'h00000001, 4'hF, 0, 2'b00, 32'h0,        C2};
    vecs[8]  = '{1, 6'h0C, 32'hA5A5A5A5, 4'h8, 1, 2'b00, 32'h0,        C3};
    vecs[9]  = '{1, 6'h0C, 32'hFFFFFFFF, 4'h0, 2, 2'b00, 32'h0,        C3};
    vecs[10] = '{0, 6'h0C, 32'h0,        4'h0, 0, 2'b00, 32'hA5000000, C3};
    vecs[11] = '{0, 6'h10, 32'h0,        4'h0, 0, 2'b00, S0,           C3};
    vecs[12] = '{0, 6'h1E, 32'h0,        4'h0, 0, 2'b00, S3,           C3};
    vecs[13] = '{0, 6'h23, 32'h0,        4'h0, 0, 2'b00, 32'h00123456, C3};
    vecs[14] = '{1, 6'h08, 32'h12345678, 4'h3, 2, 2'b00, 32'h0,        C4};
    vecs[15] = '{0, 6'h3C, 32'h0,        4'h0, 0, 2'b10, 32'h0,        C4};
    vecs[16] = '{1, 6'h24, 32'h33333333, 4'hF, 0, 2'b10, 32'h0,        C4};
    vecs[17] = '{1, 6'h1C, 32'h44444444, 4'hF, 1, 2'b10, 32'h0,        C4};

    status_in = {S3, S2, S1, S0};

    // Reset state.
    repeat (3) @(posedge clk);
    #1 areset = 0;
    check("reset_ready_valid", {awready, wready, arready, bvalid, rvalid}, 5'b11100);
    check("reset_resp_data", {bresp, rresp, rdata}, 36'h0);
    check("reset_ctrl", ctrl_out, C0);

    // Table-driven transactions.
    for (int i = 0; i < NVEC; i++) begin
      if (vecs[i].is_wr) begin
        axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].order, resp);
        check($sformatf("v%0d_bresp", i), resp, vecs[i].exp_resp);
        $display("vec %0d: WR addr=%h data=%h strb=%h order=%0d bresp=%0d",
                 i, vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].order, resp);
      end else begin
        axi_read(vecs[i].addr, rd, resp);
        check($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rdata);
        check($sformatf("v%0d_rresp", i), resp, vecs[i].exp_resp);
        $display("vec %0d: RD addr=%h rdata=%h rresp=%0d", i, vecs[i].addr, rd, resp);
      end
      check($sformatf("v%0d_ctrl", i), ctrl_out, vecs[i].exp_ctrl);
    end

    // rdata held while rready is low even though status_in moves.
    araddr = 6'h18; arvalid = 1;
    check("stab_arready", arready, 1'b1);
    @(posedge clk); #1;
    arvalid = 0;
    for (int k = 0; k < 3; k++) begin
      status_in[95:64] = 32'h1000_0000 * (k + 1) + 32'h77;
      @(posedge clk); #1;
      check($sformatf("stab_rdata_%0d", k), {rvalid, rresp, rdata}, {1'b1, 2'b00, S2});
    end
    rready = 1; @(posedge clk); #1; rready = 0;
    status_in = {S3, S2, S1, S0};
    $display("seq stable-read: rdata held at %h", S2);

    // Commit to reg0 (1 -> 2) in the same cycle as a read capture of reg0.
    awaddr = 6'h00; wdata = 32'h2; wstrb = 4'hF; awvalid = 1; wvalid = 1;
    check("same_aw_ready", {awready, wready}, 2'b11);
    @(posedge clk); #1;
    awvalid = 0; wvalid = 0;
    check("same_bvalid", {bvalid, bresp}, 3'b100);
    araddr = 6'h00; arvalid = 1;
    check("same_arready", arready, 1'b1);
    @(posedge clk); #1;
    arvalid = 0;
    check("same_rdata_old", {rvalid, rdata}, {1'b1, 32'h1});
    check("same_ctrl_new", ctrl_out[31:0], 32'h2);
    rready = 1; bready = 1;
    @(posedge clk); #1;
    rready = 0; bready = 0;
    axi_read(6'h00, rd, resp);
    check("same_next_read", rd, 32'h2);
    $display("seq same-cycle: captured old=1, next read=%h", rd);

    // Reset while bvalid is pending.
    awaddr = 6'h04; wdata = 32'h5; wstrb = 4'hF; awvalid = 1; wvalid = 1;
    @(posedge clk); #1;
    awvalid = 0; wvalid = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_pre_bvalid", bvalid, 1'b1);
    areset = 1;
    @(posedge clk); #1;
    areset = 0;
    check("rst_mid_handshake", {awready, wready, arready, bvalid, rvalid}, 5'b11100);
    check("rst_mid_resp_data", {bresp, rresp, rdata}, 36'h0);
    check("rst_mid_ctrl", ctrl_out, C0);
`ifdef PERIF_REGBANK_WR_PULSE_EN
    check("rst_wr_pulse", wr_pulse, 4'h0);
`endif
    $display("seq reset-during-bvalid: ctrl=%h", ctrl_out);

    // Reset landing on the commit cycle: nothing may be written.
    awaddr = 6'h08; wdata = 32'hFF; wstrb = 4'hF; awvalid = 1; wvalid = 1;
    @(posedge clk); #1;
    awvalid = 0; wvalid = 0;
    areset = 1;
    @(posedge clk); #1;
    areset = 0;
    check("rst_commit_ctrl", ctrl_out, C0);
    check("rst_commit_bvalid", bvalid, 1'b0);
    axi_read(6'h08, rd, resp);
    check("rst_commit_read", rd, 32'h0);
    $display("seq reset-during-commit: reg2=%h", rd);

`ifdef PERIF_REGBANK_WR_PULSE_EN
    mon_en = 1;
    axi_write(6'h0C, 32'hFFFFFFFF, 4'h0, 0, resp);
    check("pulse_bresp", resp, 2'b00);
    axi_write(6'h10, 32'h1, 4'hF, 0, resp);
    check("pulse_slverr_bresp", resp, 2'b10);
    @(posedge clk); #1;
    mon_en = 0;
    check("pulse3_count", pulse3_cnt, 1);
    check("pulse_other_count", pulse_other_cnt, 0);
    check("pulse_ctrl_unchanged", ctrl_out, C0);
    $display("seq wr_pulse: bit3 pulses=%0d others=%0d", pulse3_cnt, pulse_other_cnt);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
